// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of NUM_Q FIFOs onto one registered valid/ready stream.
// Optional burst mode (repeat grants to one queue) is enabled by defining FIFO_SCHED_BURST_EN.
module fifo_rr_scheduler #(
  parameter int WIDTH     = 8,
  parameter int NUM_Q     = 4,
  parameter int QID_W     = $clog2(NUM_Q),
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_Q-1:0]       q_mask,
  input  logic [NUM_Q-1:0]       q_empty,
  input  logic [NUM_Q*WIDTH-1:0] q_data,
  output logic [NUM_Q-1:0]       q_pop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [QID_W-1:0]       out_qid
);

  logic [NUM_Q-1:0] eligible_s;
  logic [WIDTH-1:0] q_word_s [NUM_Q];
  logic             slot_free_s;
  logic             rr_found_s;
  logic [QID_W-1:0] rr_idx_s;
  logic [QID_W-1:0] rr_cand_s;
  int               rr_sum_s;
  logic             grant_v_s;
  logic [QID_W-1:0] grant_idx_s;
  logic             burst_hold_s;
  logic [QID_W-1:0] last_grant_r;

  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_word
    assign q_word_s[gi] = q_data[gi*WIDTH +: WIDTH];
  end

  // Eligibility and output-slot availability.
  always_comb begin
    eligible_s  = q_mask & ~q_empty;
    slot_free_s = ~out_valid | out_ready;
  end

  // Round-robin search starting just after the last granted queue.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {QID_W{1'b0}};
    rr_sum_s   = 0;
    rr_cand_s  = {QID_W{1'b0}};
    for (int k = 1; k <= NUM_Q; k++) begin
      rr_sum_s = int'(last_grant_r) + k;
      if (rr_sum_s >= NUM_Q) begin
        rr_sum_s = rr_sum_s - NUM_Q;
      end else begin
        rr_sum_s = rr_sum_s;
      end
      rr_cand_s = QID_W'(rr_sum_s);
      if (!rr_found_s && eligible_s[rr_cand_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = rr_cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef FIFO_SCHED_BURST_EN
  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BC_W-1:0] burst_cnt_r;
  logic            burst_live_r;

  // Stay on the previous queue while it is still eligible and the burst budget remains.
  always_comb begin
    burst_hold_s = burst_live_r & eligible_s[last_grant_r] &
                   (int'(burst_cnt_r) < (MAX_BURST - 1));
  end

  // Burst counter: counts repeat grants; a new queue or en=0 restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r  <= {BC_W{1'b0}};
      burst_live_r <= 1'b0;
    end else if (!en) begin
      burst_cnt_r  <= {BC_W{1'b0}};
      burst_live_r <= 1'b0;
    end else if (grant_v_s) begin
      burst_live_r <= 1'b1;
      if (burst_hold_s) begin
        burst_cnt_r <= burst_cnt_r + BC_W'(1);
      end else begin
        burst_cnt_r <= {BC_W{1'b0}};
      end
    end else begin
      burst_cnt_r  <= burst_cnt_r;
      burst_live_r <= burst_live_r;
    end
  end
`else
  // Pure round-robin build: never hold on the previous queue.
  always_comb begin
    burst_hold_s = 1'b0;
  end
`endif

  // Grant decision for this cycle.
  always_comb begin
    grant_v_s   = 1'b0;
    grant_idx_s = rr_idx_s;
    if (en && slot_free_s && rr_found_s) begin
      grant_v_s = 1'b1;
      if (burst_hold_s) begin
        grant_idx_s = last_grant_r;
      end else begin
        grant_idx_s = rr_idx_s;
      end
    end else begin
      grant_v_s = 1'b0;
    end
  end

  // One-hot pop strobe, suppressed while reset is asserted.
  always_comb begin
    q_pop = {NUM_Q{1'b0}};
    if (grant_v_s && rst_n) begin
      q_pop[grant_idx_s] = 1'b1;
    end else begin
      q_pop = {NUM_Q{1'b0}};
    end
  end

  // Output register: load on grant, drop valid when the slot is free but idle, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= {WIDTH{1'b0}};
      out_qid      <= {QID_W{1'b0}};
      last_grant_r <= QID_W'(NUM_Q - 1);
    end else if (slot_free_s) begin
      if (grant_v_s) begin
        out_valid    <= 1'b1;
        out_data     <= q_word_s[grant_idx_s];
        out_qid      <= grant_idx_s;
        last_grant_r <= grant_idx_s;
      end else begin
        out_valid    <= 1'b0;
        out_data     <= out_data;
        out_qid      <= out_qid;
        last_grant_r <= last_grant_r;
      end
    end else begin
      out_valid    <= out_valid;
      out_data     <= out_data;
      out_qid      <= out_qid;
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed self-checking bench for fifo_rr_scheduler with a behavioural FIFO model per queue.
// Expectations follow the default build; burst-build sequences are selected by FIFO_SCHED_BURST_EN.
module tb_fifo_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  q_mask;
  logic [3:0]  q_empty;
  logic [31:0] q_data;
  logic [3:0]  q_pop;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_qid;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [4][32];
  int         head [4];
  int         cnt  [4];
  logic [3:0] pops;

  fifo_rr_scheduler #(.WIDTH(8), .NUM_Q(4), .QID_W(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .q_mask(q_mask), .q_empty(q_empty),
    .q_data(q_data), .q_pop(q_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_qid(out_qid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      q_empty[i]        = (cnt[i] == 0);
      q_data[i*8 +: 8]  = (cnt[i] != 0) ? mem[i][head[i]] : 8'h00;
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
    refresh();
  endtask

  task automatic push(input int q, input logic [7:0] d);
    mem[q][head[q] + cnt[q]] = d;
    cnt[q]++;
    refresh();
  endtask

  // Capture pops just before the edge, then retire them in the FIFO model after the edge.
  task automatic tick();
    #1;
    pops = q_pop;
    chk("pop_of_empty", {28'd0, pops & q_empty}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pops[i] && cnt[i] > 0) begin
        head[i]++;
        cnt[i]--;
      end
    end
    refresh();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    q_mask    = 4'hF;
    out_ready = 1'b1;
    clear_fifos();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_all(input int n);
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < n; k++) begin
        push(q, 8'(q*16 + k));
      end
    end
  endtask

  initial begin
    int eq;
    int ed;
    rst_n     = 1'b0;
    en        = 1'b1;
    q_mask    = 4'hF;
    out_ready = 1'b1;
    clear_fifos();
    push(1, 8'h5A);
    #2;
    chk("rst_pop", {28'd0, q_pop}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_qid", {30'd0, out_qid}, 32'd0);
    tick();
    clear_fifos();
    rst_n = 1'b1;

    // Idle: all empty for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_pop", {28'd0, q_pop}, 32'd0);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
    end

    // Single queue q1 holding A5, 3C.
    push(1, 8'hA5);
    push(1, 8'h3C);
    #1;
    chk("sq_pop0", {28'd0, q_pop}, 32'h2);
    tick();
    chk("sq_valid0", {31'd0, out_valid}, 32'd1);
    chk("sq_data0", {24'd0, out_data}, 32'hA5);
    chk("sq_qid0", {30'd0, out_qid}, 32'd1);
    #1;
    chk("sq_pop1", {28'd0, q_pop}, 32'h2);
    tick();
    chk("sq_data1", {24'd0, out_data}, 32'h3C);
    chk("sq_qid1", {30'd0, out_qid}, 32'd1);
    #1;
    chk("sq_pop2", {28'd0, q_pop}, 32'h0);
    tick();
    chk("sq_valid_end", {31'd0, out_valid}, 32'd0);
    chk("sq_data_hold", {24'd0, out_data}, 32'h3C);

    // All four queues full, ready held high.
    do_reset();
    fill_all(8);
    for (int k = 0; k < 8; k++) begin
`ifdef FIFO_SCHED_BURST_EN
      eq = k / 4;
      ed = eq * 16 + (k % 4);
`else
      eq = k % 4;
      ed = eq * 16 + (k / 4);
`endif
      #1;
      chk("full_pop", {28'd0, q_pop}, 32'd1 << eq);
      tick();
      chk("full_valid", {31'd0, out_valid}, 32'd1);
      chk("full_qid", {30'd0, out_qid}, eq);
      chk("full_data", {24'd0, out_data}, ed);
    end

    // Backpressure on word 77 from q2.
    do_reset();
    out_ready = 1'b0;
    push(2, 8'h77);
    #1;
    chk("bp_pop_q2", {28'd0, q_pop}, 32'h4);
    tick();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_data", {24'd0, out_data}, 32'h77);
    push(0, 8'h11);
    push(1, 8'h22);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_pop_hold", {28'd0, q_pop}, 32'h0);
      tick();
      chk("bp_data_hold", {24'd0, out_data}, 32'h77);
      chk("bp_qid_hold", {30'd0, out_qid}, 32'd2);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_cnt0", cnt[0], 32'd1);
      chk("bp_cnt1", cnt[1], 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_pop_q0", {28'd0, q_pop}, 32'h1);
    tick();
    chk("bp_data_q0", {24'd0, out_data}, 32'h11);
    chk("bp_qid_q0", {30'd0, out_qid}, 32'd0);
    #1;
    chk("bp_pop_q1", {28'd0, q_pop}, 32'h2);
    tick();
    chk("bp_data_q1", {24'd0, out_data}, 32'h22);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

`ifndef FIFO_SCHED_BURST_EN
    // Mask 1011 and en behaviour.
    do_reset();
    fill_all(4);
    q_mask = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      eq = (k % 3 == 2) ? 3 : (k % 3);
      ed = eq * 16 + (k / 3);
      tick();
      chk("mask_qid", {30'd0, out_qid}, eq);
      chk("mask_data", {24'd0, out_data}, ed);
    end
    en = 1'b0;
    #1;
    chk("en0_pop", {28'd0, q_pop}, 32'h0);
    tick();
    chk("en0_valid", {31'd0, out_valid}, 32'd0);
    chk("mask_q2_untouched", cnt[2], 32'd4);
    out_ready = 1'b0;
    en        = 1'b1;
    #1;
    chk("pend_pop", {28'd0, q_pop}, 32'h1);
    tick();
    chk("pend_data", {24'd0, out_data}, 32'h02);
    en = 1'b0;
    tick();
    chk("pend_valid_hold", {31'd0, out_valid}, 32'd1);
    chk("pend_data_hold", {24'd0, out_data}, 32'h02);
    out_ready = 1'b1;
    #1;
    chk("pend_en0_pop", {28'd0, q_pop}, 32'h0);
    tick();
    chk("pend_accepted", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    #1;
    chk("lastgrant_kept_pop", {28'd0, q_pop}, 32'h2);
    tick();
    chk("lastgrant_kept_data", {24'd0, out_data}, 32'h12);
    q_mask = 4'hF;
`endif

    // Reset pulsed mid-stream.
    do_reset();
    fill_all(4);
    tick();
    tick();
    chk("mid_valid_pre", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_valid_rst", {31'd0, out_valid}, 32'd0);
    chk("mid_pop_rst", {28'd0, q_pop}, 32'h0);
    clear_fifos();
    for (int q = 0; q < 4; q++) begin
      push(q, 8'(8'hA0 + q));
    end
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_first_pop", {28'd0, q_pop}, 32'h1);
    tick();
    chk("mid_first_qid", {30'd0, out_qid}, 32'd0);
    chk("mid_first_data", {24'd0, out_data}, 32'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
